apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- Single-outstanding APB requester that sits directly upstream of the team's APB SRAM slave.
- Accepts a read or write command on a valid/ready interface and drives one APB transfer: SETUP, then ACCESS, then a PREADY-terminated end of transfer.
- Returns read data and the error status on a valid/ready response interface.
- Lets test sequencers and future bus-bridge logic reach APB slaves without hand-driving PSEL/PENABLE.

Parameters:
- ADDR_BUS_WIDTH, 32, width of PADDR and cmd_addr.
- DATA_BUS_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYC, 16, ACCESS cycles without PREADY before abort; used only with APB_CMD_TIMEOUT_EN; must be >= 1.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_BUS_WIDTH  target address.
- cmd_wdata  in  DATA_BUS_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_rdata  out  DATA_BUS_WIDTH  read data; 0 for writes.
- rsp_slverr  out  1  PSLVERR captured at end of transfer, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout; constant 0 without the feature.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_BUS_WIDTH  APB address.
- PWDATA  out  DATA_BUS_WIDTH  APB write data.
- PRDATA  in  DATA_BUS_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Clock and reset: one clock, PCLK; reset PRESET is synchronous and active-high.
- Reset values: state IDLE; every output 0, including the PADDR/PWDATA/PWRITE holding registers.
- Reset mid-transfer: abandons the transfer at that edge; PSEL drops the following cycle; no response is produced.
- All outputs are registered. cmd_ready = (state == IDLE).
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - PSEL = 0, PENABLE = 0.
  - On handshake at edge N: capture cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA; go to SETUP.
- SETUP (cycle N+1):
  - PSEL = 1, PENABLE = 0.
  - PREADY is ignored in this state, even if the slave raises it early.
  - Unconditionally go to ACCESS.
- ACCESS (from N+2):
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE and PWDATA are held stable.
  - PREADY = 0 at an edge: stay in ACCESS (wait state).
  - PREADY = 1 at edge M:
    - rsp_rdata <= PRDATA for reads, 0 for writes.
    - rsp_slverr <= PSLVERR.
    - rsp_timeout <= 0.
    - Go to RESP.
- RESP (from M+1):
  - PSEL = 0, PENABLE = 0.
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On handshake: go to IDLE; rsp_valid drops the next cycle.
- Address/data after the transfer: PADDR/PWDATA/PWRITE keep their last values after the transfer; they are not zeroed.
- Throughput: minimum 4 cycles per command (IDLE, SETUP, ACCESS, RESP) with PREADY=1 and rsp_ready=1.
- Back-pressure: cmd_valid held while not ready is simply held off. rsp_ready low stalls in RESP indefinitely.
- Range checking: none in this block; PSLVERR is passed through as reported by the slave.

Optional Feature:
- Macro: APB_CMD_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYC: go to RESP with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0; PSEL/PENABLE drop.
  - PREADY = 1 on the same edge as expiry wins, giving a normal completion.
- Undefined: ACCESS waits forever; no counter logic; rsp_timeout tied 0.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - localparams WRITE = 1, READ = 0;
  - response struct {rdata, slverr, timeout} parameterised by DATA_BUS_WIDTH via the module.
- Sub-module apb_wait_timer (load/count/expired, width $clog2(TIMEOUT_CYC+1)), instantiated only under APB_CMD_TIMEOUT_EN.
- FSM and datapath stay in apb_cmd_master.

Test Plan:
- Write addr 0x3, data 0xDEADBEEF, zero-wait slave:
  - PSEL high for 2 cycles, PENABLE high for 1;
  - rsp_valid 3 cycles after accept; rsp_slverr = 0; rsp_rdata = 0.
- Read addr 0x3 after the write above, against the APB SRAM slave model: rsp_rdata = 0xDEADBEEF, rsp_slverr = 0.
- Read addr 0x40 (MEMSIZE 64): rsp_slverr = 1; the next command is accepted normally.
- Slave inserts 2 wait states (PREADY low for 2 ACCESS cycles):
  - PENABLE high for 3 cycles;
  - PADDR/PWDATA constant throughout;
  - response 1 cycle after PREADY.
- Timeout, with APB_CMD_TIMEOUT_EN and TIMEOUT_CYC = 4, PREADY tied 0: after 4 ACCESS cycles, rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
- Reset and back-pressure:
  - PRESET asserted during ACCESS: next cycle all outputs 0, no rsp_valid.
  - rsp_ready held 0 for 5 cycles: rsp_valid and data stable, cmd_ready = 0 throughout.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command master.
// Build option: define APB_CMD_TIMEOUT_EN to enable the ACCESS-phase wait timeout.
package apb_pkg;

  // Transfer phases of the single-outstanding APB requester.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Encoding of cmd_write / PWRITE.
  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles and flags the cycle whose edge would reach TIMEOUT_CYC.
// Only instantiated when APB_CMD_TIMEOUT_EN is defined.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear on entry to ACCESS, step on each wait cycle, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (count && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = count && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule : apb_wait_timer

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB requester: command in, one APB transfer, response out.
// Build option: APB_CMD_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYC wait cycles.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_BUS_WIDTH = 32,
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYC    = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_BUS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_BUS_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_BUS_WIDTH-1:0] PADDR,
  output logic [DATA_BUS_WIDTH-1:0] PWDATA,
  input  logic [DATA_BUS_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  // The response struct depends on the data width, so it lives here rather than in the package.
  typedef struct packed {
    logic [DATA_BUS_WIDTH-1:0] rdata;
    logic                      slverr;
    logic                      timeout;
  } rsp_t;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYC must be >= 1");
  end

  apb_state_e                state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [ADDR_BUS_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_BUS_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      rsp_valid_q, rsp_valid_d;
  rsp_t                      rsp_q, rsp_d;

`ifdef APB_CMD_TIMEOUT_EN
  logic timer_load;
  logic timer_count;
  logic timer_expired;

  assign timer_load  = (state_q == SETUP);
  assign timer_count = (state_q == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .load   (timer_load),
    .count  (timer_count),
    .expired(timer_expired)
  );
`endif

  // Next state and next registered outputs; every output is a flop so the bus sees clean edges.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d    = cmd_write ? WRITE : READ;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          state_d     = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          rsp_d.rdata   = (pwrite_q == READ) ? PRDATA : '0;
          rsp_d.slverr  = PSLVERR;
          rsp_d.timeout = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end
`ifdef APB_CMD_TIMEOUT_EN
        else if (timer_expired) begin
          rsp_d.rdata   = '0;
          rsp_d.slverr  = 1'b1;
          rsp_d.timeout = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end
`endif
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer and zeroes every output.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_slverr  = rsp_q.slverr;
  assign rsp_timeout = rsp_q.timeout;

endmodule : apb_cmd_master

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master against a small APB SRAM slave model (64 words).
// Build option: define APB_CMD_TIMEOUT_EN to also run the timeout step (TIMEOUT_CYC = 4).
module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int errors = 0;
  int checks = 0;

  // Slave model controls.
  int   wait_cfg = 0;
  logic early    = 1'b0;
  logic stall    = 1'b0;
  int   acc_cnt  = 0;
  logic [31:0] mem [64];

  apb_cmd_master #(
    .ADDR_BUS_WIDTH(32),
    .DATA_BUS_WIDTH(32),
    .TIMEOUT_CYC   (4)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // APB SRAM slave: wait_cfg wait states, optional early PREADY in SETUP, stall holds PREADY low.
  always_comb begin
    PREADY = 1'b0;
    if (!stall && PSEL) begin
      PREADY = PENABLE ? (acc_cnt >= wait_cfg) : early;
    end
    PRDATA  = (PADDR < 32'd64) ? mem[PADDR[5:0]] : 32'hBAD0_0000;
    PSLVERR = PSEL && PENABLE && PREADY && (PADDR >= 32'd64);
  end

  // Slave wait-state counter and memory write port.
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else if (!PENABLE)              acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && (PADDR < 32'd64)) mem[PADDR[5:0]] <= PWDATA;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it until rsp_valid, recording bus activity.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input int budget, output int psel_n, output int pen_n,
                               output int lat, output logic stable, output logic done);
    int n;
    psel_n = 0; pen_n = 0; lat = 0; stable = 1'b1; done = 1'b0;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < budget) begin
      tick();
      n++;
    end
    if (cmd_ready) begin
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < budget; i++) begin
        if (rsp_valid) begin
          done = 1'b1;
          break;
        end
        if (PSEL) psel_n++;
        if (PENABLE) pen_n++;
        if (PSEL && (PADDR !== addr || PWDATA !== data || PWRITE !== wr)) stable = 1'b0;
        tick();
        lat++;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic takeResponse();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int   psel_n, pen_n, lat;
    logic stable, done, flag;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;

    // Reset state.
    tick(); tick();
    checkOutput("rst_ctrl", 64'({PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, rsp_slverr, rsp_timeout}), 64'h0);
    checkOutput("rst_paddr", 64'(PADDR), 64'h0);
    checkOutput("rst_pwdata", 64'(PWDATA), 64'h0);
    checkOutput("rst_rdata", 64'(rsp_rdata), 64'h0);
    PRESET = 1'b0;
    tick();
    checkOutput("idle_cmd_ready", 64'(cmd_ready), 64'h1);

    // Write 0x3 <- 0xDEADBEEF, zero-wait slave that raises PREADY already in SETUP.
    early = 1'b1; wait_cfg = 0;
    applyStimulus(1'b1, 32'h3, 32'hDEAD_BEEF, 50, psel_n, pen_n, lat, stable, done);
    checkOutput("wr_done", 64'(done), 64'h1);
    checkOutput("wr_psel_cycles", 64'(psel_n), 64'd2);
    checkOutput("wr_penable_cycles", 64'(pen_n), 64'd1);
    checkOutput("wr_latency", 64'(lat), 64'd2);
    checkOutput("wr_resp", 64'({rsp_slverr, rsp_timeout, rsp_rdata}), 64'h0);
    checkOutput("wr_resp_cmd_ready", 64'(cmd_ready), 64'h0);
    takeResponse();
    checkOutput("wr_after_ctrl", 64'({rsp_valid, cmd_ready, PSEL, PENABLE}), 64'b0100);
    checkOutput("wr_after_paddr_held", 64'({PWRITE, PADDR}), {31'h0, 1'b1, 32'h3});
    early = 1'b0;

    // Read 0x3 back.
    applyStimulus(1'b0, 32'h3, 32'h0, 50, psel_n, pen_n, lat, stable, done);
    checkOutput("rd3_done_lat", 64'({done, 8'(lat)}), {55'h0, 1'b1, 8'd2});
    checkOutput("rd3_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    checkOutput("rd3_slverr", 64'(rsp_slverr), 64'h0);
    takeResponse();

    // Out-of-range read: slave error and PRDATA passed through.
    applyStimulus(1'b0, 32'h40, 32'h0, 50, psel_n, pen_n, lat, stable, done);
    checkOutput("rd40_done", 64'(done), 64'h1);
    checkOutput("rd40_slverr", 64'(rsp_slverr), 64'h1);
    checkOutput("rd40_rdata", 64'(rsp_rdata), 64'hBAD0_0000);
    takeResponse();

    // Next command after the error is accepted normally.
    applyStimulus(1'b1, 32'h10, 32'h1234_5678, 50, psel_n, pen_n, lat, stable, done);
    checkOutput("post_err_wr", 64'({done, rsp_slverr, 8'(lat)}), {54'h0, 2'b10, 8'd2});
    takeResponse();

    // Two wait states on a write, then read it back with two wait states.
    wait_cfg = 2;
    applyStimulus(1'b1, 32'h11, 32'hCAFE_F00D, 50, psel_n, pen_n, lat, stable, done);
    checkOutput("ws_wr_done", 64'(done), 64'h1);
    checkOutput("ws_wr_penable_cycles", 64'(pen_n), 64'd3);
    checkOutput("ws_wr_stable", 64'(stable), 64'h1);
    checkOutput("ws_wr_latency", 64'(lat), 64'd4);
    takeResponse();
    applyStimulus(1'b0, 32'h11, 32'h0, 50, psel_n, pen_n, lat, stable, done);
    checkOutput("ws_rd_pen_lat", 64'({8'(pen_n), 8'(lat)}), {48'h0, 8'd3, 8'd4});
    checkOutput("ws_rd_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
    takeResponse();
    applyStimulus(1'b0, 32'h10, 32'h0, 50, psel_n, pen_n, lat, stable, done);
    checkOutput("ws_rd10_rdata", 64'(rsp_rdata), 64'h1234_5678);
    wait_cfg = 0;

    // Response back-pressure: hold rsp_ready low for 5 cycles with another command waiting.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3;
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(rsp_valid === 1'b1 && rsp_rdata === 32'h1234_5678 && cmd_ready === 1'b0 && PSEL === 1'b0))
        flag = 1'b0;
      tick();
    end
    cmd_valid = 1'b0;
    checkOutput("bp_stable", 64'(flag), 64'h1);
    takeResponse();
    checkOutput("bp_released", 64'({rsp_valid, cmd_ready}), 64'b01);

`ifdef APB_CMD_TIMEOUT_EN
    // Timeout: PREADY held low, abort after 4 ACCESS cycles.
    stall = 1'b1;
    applyStimulus(1'b0, 32'h7, 32'h0, 50, psel_n, pen_n, lat, stable, done);
    checkOutput("to_done", 64'(done), 64'h1);
    checkOutput("to_penable_cycles", 64'(pen_n), 64'd4);
    checkOutput("to_latency", 64'(lat), 64'd5);
    checkOutput("to_resp", 64'({rsp_slverr, rsp_timeout, rsp_rdata}), {30'h0, 2'b11, 32'h0});
    checkOutput("to_bus_idle", 64'({PSEL, PENABLE}), 64'h0);
    takeResponse();
    stall = 1'b0;
`endif

    // Reset during ACCESS.
    stall = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5; cmd_wdata = 32'h5555_AAAA;
    tick();
    cmd_valid = 1'b0;
    tick();
    checkOutput("pre_rst_access", 64'({PSEL, PENABLE}), 64'b11);
`ifndef APB_CMD_TIMEOUT_EN
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!(PENABLE === 1'b1 && rsp_valid === 1'b0 && rsp_timeout === 1'b0)) flag = 1'b0;
      tick();
    end
    checkOutput("no_timeout_wait", 64'(flag), 64'h1);
`endif
    PRESET = 1'b1;
    tick();
    checkOutput("mid_rst_ctrl", 64'({PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, rsp_slverr, rsp_timeout}), 64'h0);
    checkOutput("mid_rst_paddr_pwdata", {PADDR, PWDATA}, 64'h0);
    checkOutput("mid_rst_rdata", 64'(rsp_rdata), 64'h0);
    PRESET = 1'b0; stall = 1'b0;
    flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) flag = 1'b0;
    end
    checkOutput("post_rst_no_rsp", 64'({flag, cmd_ready}), 64'b11);
    checkOutput("post_rst_mem5_untouched", 64'(mem[5]), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_apb_cmd_master
